// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings and FSM states.
package md_pkg;
  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_t;
endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned 32-bit divider; quotient truncates toward zero,
// remainder takes the sign of the dividend.
module md_div_core (
  input  logic        sign_mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_zero
);
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    div_zero = (b == '0);
    mag_a    = (sign_mode && a[31]) ? (~a + 32'd1) : a;
    mag_b    = (sign_mode && b[31]) ? (~b + 32'd1) : b;
    uq       = '0;
    ur       = '0;
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    // 0x80000000 / -1 wraps back to 0x80000000 through the negation
    quo = (sign_mode && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
    rem = (sign_mode && a[31]) ? (~ur + 32'd1) : ur;
  end
endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding HI/LO; results are computed at start and
// committed after a fixed busy window.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op_E,
  input  logic [31:0]        a_E,
  input  logic [31:0]        b_E,
  output logic               start,
  output logic               busy,
  output logic [31:0]        hi_E,
  output logic [31:0]        lo_E
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  md_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic              pend_valid;

  logic              is_md_op;
  logic              is_div;
  logic [63:0]       prod;
  logic [31:0]       quo;
  logic [31:0]       rem;
  logic              div_zero;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              res_valid;
  logic [CNT_W-1:0]  run_len;

  md_div_core u_div (
    .sign_mode (md_op_E == MD_DIV),
    .a         (a_E),
    .b         (b_E),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always_comb begin
    is_md_op = (md_op_E == MD_MULT) || (md_op_E == MD_MULTU) ||
               (md_op_E == MD_DIV)  || (md_op_E == MD_DIVU);
    is_div   = (md_op_E == MD_DIV) || (md_op_E == MD_DIVU);
    start    = is_md_op && !busy;

    if (md_op_E == MD_MULT)
      prod = $signed({{32{a_E[31]}}, a_E}) * $signed({{32{b_E[31]}}, b_E});
    else
      prod = {32'd0, a_E} * {32'd0, b_E};

    if (is_div) begin
      res_hi    = rem;
      res_lo    = quo;
      res_valid = !div_zero;
      run_len   = CNT_W'(DIV_CYCLES - 1);
    end else begin
      res_hi    = prod[63:32];
      res_lo    = prod[31:0];
      res_valid = 1'b1;
      run_len   = CNT_W'(MULT_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      count      <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      hi_E       <= '0;
      lo_E       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            count      <= run_len;
            pend_hi    <= res_hi;
            pend_lo    <= res_lo;
            pend_valid <= res_valid;
          end else if (md_op_E == MD_MTHI) begin
            hi_E <= a_E;
          end else if (md_op_E == MD_MTLO) begin
            lo_E <= a_E;
          end
        end
        ST_RUN: begin
          if (count == '0) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            pend_valid <= 1'b0;
            if (pend_valid) begin
              hi_E <= pend_hi;
              lo_E <= pend_lo;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vectors plus randomized ops against
// an arithmetic model of HI/LO and the busy window.
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] a_E;
  logic [31:0] b_E;
  logic        start;
  logic        busy;
  logic [31:0] hi_E;
  logic [31:0] lo_E;

  int checks;
  int errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op_E (md_op_E),
    .a_E     (a_E),
    .b_E     (b_E),
    .start   (start),
    .busy    (busy),
    .hi_E    (hi_E),
    .lo_E    (lo_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: updates m_hi/m_lo from op semantics, returns busy length (0 = none).
  function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    longint unsigned up;
    logic [63:0] p;
    case (op)
      3'd1: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0];
        return MULT_N;
      end
      3'd2: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        p = up; m_hi = p[63:32]; m_lo = p[31:0];
        return MULT_N;
      end
      3'd3: begin
        if (b != 0) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          m_lo = 32'(q); m_hi = 32'(r);
        end
        return DIV_N;
      end
      3'd4: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        return DIV_N;
      end
      3'd5: begin m_hi = a; return 0; end
      3'd6: begin m_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Issue one op for a single cycle, then check busy window and committed HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] old_hi, old_lo;
    logic        exp_start;
    int          n;
    old_hi = m_hi; old_lo = m_lo;
    @(negedge clk);
    md_op_E = op; a_E = a; b_E = b;
    exp_start = (op >= 3'd1 && op <= 3'd4);
    #1;
    checks++;
    if (start !== exp_start) begin
      errors++; $display("FAIL %s start got %b want %b", name, start, exp_start);
    end
    n = model_op(op, a, b);
    @(negedge clk);
    md_op_E = 3'd0; a_E = $urandom; b_E = $urandom;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (busy !== 1'b1 || hi_E !== old_hi || lo_E !== old_lo || start !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_cycle%0d busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h", name, i + 1, busy, hi_E, lo_E, old_hi, old_lo);
      end
      @(negedge clk);
      a_E = $urandom; b_E = $urandom;
    end
    checks++;
    if (busy !== 1'b0 || hi_E !== m_hi || lo_E !== m_lo) begin
      errors++;
      $display("FAIL %s result busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", name, busy, hi_E, lo_E, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    md_op_E = 3'd0; a_E = '0; b_E = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi_E !== 32'd0 || lo_E !== 32'd0 || start !== 1'b0) begin
      errors++; $display("FAIL reset busy=%b hi=%h lo=%h start=%b want 0", busy, hi_E, lo_E, start);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    run_op("mult_neg", 3'd1, 32'd3, 32'hFFFFFFFE);
    checks++;
    if (hi_E !== 32'hFFFFFFFF || lo_E !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_const hi=%h lo=%h want ffffffff fffffffa", hi_E, lo_E);
    end
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2);
    checks++;
    if (hi_E !== 32'h1 || lo_E !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_const hi=%h lo=%h want 00000001 fffffffe", hi_E, lo_E);
    end
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (hi_E !== 32'hFFFFFFFF || lo_E !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_const hi=%h lo=%h want ffffffff fffffffd", hi_E, lo_E);
    end
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (hi_E !== 32'h0 || lo_E !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf_const hi=%h lo=%h want 00000000 80000000", hi_E, lo_E);
    end
    run_op("mthi", 3'd5, 32'h11, 32'hDEAD);
    run_op("mtlo", 3'd6, 32'h22, 32'hBEEF);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0);
    checks++;
    if (hi_E !== 32'h11 || lo_E !== 32'h22) begin
      errors++; $display("FAIL divzero_const hi=%h lo=%h want 00000011 00000022", hi_E, lo_E);
    end
    run_op("reserved", 3'd7, 32'h1234, 32'h5678);
  endtask

  task automatic test_ignore_while_busy();
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    @(negedge clk);
    md_op_E = 3'd1; a_E = 32'h00010003; b_E = 32'hFFFF0007;
    void'(model_op(3'd1, a_E, b_E));
    for (int i = 1; i <= MULT_N; i++) begin
      @(negedge clk);
      md_op_E = (i == 2) ? 3'd5 : (i == 3) ? 3'd1 : 3'd0;
      a_E = (i == 2) ? 32'h55 : $urandom;
      b_E = $urandom;
      #1;
      checks++;
      if (start !== 1'b0 || busy !== 1'b1 || hi_E !== old_hi || lo_E !== old_lo) begin
        errors++;
        $display("FAIL ignore cycle%0d start=%b busy=%b hi=%h lo=%h want 0 1 %h %h", i, start, busy, hi_E, lo_E, old_hi, old_lo);
      end
    end
    @(negedge clk);
    md_op_E = 3'd0;
    repeat (2) begin
      checks++;
      if (busy !== 1'b0 || hi_E !== m_hi || lo_E !== m_lo) begin
        errors++; $display("FAIL ignore_result busy=%b hi=%h lo=%h want 0 %h %h", busy, hi_E, lo_E, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    md_op_E = 3'd3; a_E = 32'd1000; b_E = 32'd7;
    repeat (3) begin
      @(negedge clk);
      md_op_E = 3'd0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid pre busy=%b want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi_E !== 32'd0 || lo_E !== 32'd0) begin
      errors++; $display("FAIL rst_mid async busy=%b hi=%h lo=%h want 0", busy, hi_E, lo_E);
    end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DIV_N + 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi_E !== 32'd0 || lo_E !== 32'd0) begin
        errors++; $display("FAIL rst_mid after%0d busy=%b hi=%h lo=%h want 0", i, busy, hi_E, lo_E);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(1, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_hi = '0; m_lo = '0;
    reset = 1'b0; md_op_E = 3'd0; a_E = '0; b_E = '0;
    test_reset();
    test_directed();
    test_ignore_while_busy();
    test_random();
    test_reset_mid_div();
    run_op("post_reset_mult", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
